// File: rtl/trap_pkg.sv
// Shared definitions for the trap commit block: CSR addresses, mstatus fields,
// privilege encodings and the redirect FSM state type.
package trap_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_TRAPCNT = 12'h7C0;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  localparam logic [1:0] MODE_U = 2'b00;
  localparam logic [1:0] MODE_M = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } state_t;

  // Only U and M exist, so any other MPP value collapses to U.
  function automatic logic [1:0] warl_mpp(input logic [1:0] v);
    return (v == MODE_M) ? MODE_M : MODE_U;
  endfunction
endpackage

// File: rtl/trap_csr_regs.sv
// Machine trap CSR storage, WARL write masking, read mux and privilege mode.
// Optional accepted-trap counter at 0x7C0 when TRAP_COUNTER_EN is defined.
module trap_csr_regs
  import trap_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_trap,
  input  logic        i_xret,
  input  logic        i_wren,
  input  logic [11:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_trap_pc,
  input  logic [31:0] i_trap_code,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_mode,
  output logic        o_mie,
  output logic [31:0] o_mtvec,
  output logic [31:0] o_mepc
);
  logic        r_mie;
  logic        r_mpie;
  logic [1:0]  r_mpp;
  logic [1:0]  r_mode;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtvec;
  logic [31:0] w_mstatus;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_mpp    <= MODE_U;
      r_mode   <= MODE_M;
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtvec  <= '0;
    end else if (i_trap) begin
      r_mepc   <= i_trap_pc & ~32'h3;
      r_mcause <= i_trap_code;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
      r_mpp    <= r_mode;
      r_mode   <= MODE_M;
    end else if (i_xret) begin
      r_mode <= r_mpp;
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
      r_mpp  <= MODE_U;
    end else if (i_wren) begin
      case (i_addr)
        CSR_MSTATUS: begin
          r_mie  <= i_wdata[MSTATUS_MIE];
          r_mpie <= i_wdata[MSTATUS_MPIE];
          r_mpp  <= warl_mpp(i_wdata[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO]);
        end
        // Modes 2/3 are reserved; they fall back to direct mode.
        CSR_MTVEC:  r_mtvec  <= (i_wdata[1:0] >= 2'd2) ? (i_wdata & ~32'h3) : i_wdata;
        CSR_MEPC:   r_mepc   <= i_wdata & ~32'h3;
        CSR_MCAUSE: r_mcause <= i_wdata;
        default: ;
      endcase
    end
  end

`ifdef TRAP_COUNTER_EN
  logic [31:0] r_trap_cnt;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_trap_cnt <= '0;
    end else if (i_trap) begin
      r_trap_cnt <= r_trap_cnt + 32'd1;
    end else if (i_wren && i_addr == CSR_TRAPCNT) begin
      r_trap_cnt <= i_wdata;
    end
  end
`endif

  always_comb begin
    w_mstatus = '0;
    w_mstatus[MSTATUS_MIE] = r_mie;
    w_mstatus[MSTATUS_MPIE] = r_mpie;
    w_mstatus[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO] = r_mpp;
  end

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      CSR_MSTATUS: o_rdata = w_mstatus;
      CSR_MTVEC:   o_rdata = r_mtvec;
      CSR_MEPC:    o_rdata = r_mepc;
      CSR_MCAUSE:  o_rdata = r_mcause;
`ifdef TRAP_COUNTER_EN
      CSR_TRAPCNT: o_rdata = r_trap_cnt;
`endif
      default:     o_rdata = '0;
    endcase
  end

  assign o_mode  = r_mode;
  assign o_mie   = r_mie;
  assign o_mtvec = r_mtvec;
  assign o_mepc  = r_mepc;
endmodule

// File: rtl/trap_commit.sv
// Commits trap / xRET decisions: redirect strobe, multi-cycle flush and CSR updates.
// Define TRAP_COUNTER_EN to add the accepted-trap counter CSR at 0x7C0.
module trap_commit
  import trap_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MMU_WAIT,
  input  logic        TRAP_EN,
  input  logic [31:0] TRAP_PC,
  input  logic [31:0] TRAP_CODE,
  input  logic [31:0] TRAP_JMP_TO,
  input  logic        CHMODE_DO,
  input  logic [1:0]  CHMODE_TRANS_TO,
  input  logic        CSR_WREN,
  input  logic [11:0] CSR_ADDR,
  input  logic [31:0] CSR_WDATA,
  output logic [31:0] CSR_RDATA,
  output logic        FLUSH,
  output logic        JMP_EN,
  output logic [31:0] NEW_PC,
  output logic [1:0]  MODE,
  output logic        INT_ALLOW,
  output logic [1:0]  TRAP_VEC_MODE,
  output logic [31:0] TRAP_VEC_BASE,
  output logic [1:0]  DBG_STATE
);
  // Handshake: an event or CSR write is taken on a rising edge where the FSM is
  // IDLE and MMU_WAIT is low; anything presented at other times is dropped.
  state_t      r_state;
  logic        r_flush;
  logic        r_jmp;
  logic [31:0] r_new_pc;
  logic [3:0]  r_cnt;

  logic        w_accept;
  logic        w_trap;
  logic        w_xret;
  logic        w_csr_we;
  logic        w_mie;
  logic [31:0] w_mtvec;
  logic [31:0] w_mepc;
  logic        w_unused_ok;

  assign w_accept = (r_state == ST_IDLE) && !MMU_WAIT;
  assign w_trap   = w_accept && TRAP_EN;
  assign w_xret   = w_accept && CHMODE_DO && !TRAP_EN;
  assign w_csr_we = w_accept && CSR_WREN && !TRAP_EN && !CHMODE_DO;
  // The return mode always comes from MPP, so the requested mode is informational.
  assign w_unused_ok = ^CHMODE_TRANS_TO;

  trap_csr_regs u_csr (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_trap      (w_trap),
    .i_xret      (w_xret),
    .i_wren      (w_csr_we),
    .i_addr      (CSR_ADDR),
    .i_wdata     (CSR_WDATA),
    .i_trap_pc   (TRAP_PC),
    .i_trap_code (TRAP_CODE),
    .o_rdata     (CSR_RDATA),
    .o_mode      (MODE),
    .o_mie       (w_mie),
    .o_mtvec     (w_mtvec),
    .o_mepc      (w_mepc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_flush  <= 1'b0;
      r_jmp    <= 1'b0;
      r_new_pc <= '0;
      r_cnt    <= '0;
    end else begin
      r_jmp <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_trap || w_xret) begin
            r_state  <= ST_REDIRECT;
            r_jmp    <= 1'b1;
            r_flush  <= 1'b1;
            r_new_pc <= w_trap ? TRAP_JMP_TO : w_mepc;
          end
        end
        ST_REDIRECT: begin
          if (FLUSH_CYCLES <= 1) begin
            r_state <= ST_IDLE;
            r_flush <= 1'b0;
          end else begin
            r_state <= ST_DRAIN;
            r_cnt   <= 4'(FLUSH_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (r_cnt <= 4'd1) begin
            r_state <= ST_IDLE;
            r_flush <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign FLUSH         = r_flush;
  assign JMP_EN        = r_jmp;
  assign NEW_PC        = r_new_pc;
  assign INT_ALLOW     = w_mie && (r_state == ST_IDLE);
  assign TRAP_VEC_MODE = w_mtvec[1:0];
  assign TRAP_VEC_BASE = {w_mtvec[31:2], 2'b00};
  assign DBG_STATE     = r_state;
endmodule

// File: tb/tb_trap_commit.sv
// Directed bench for trap_commit: redirect targets go through a scoreboard queue,
// CSR state and flush length are checked against hand-computed values.
module tb_trap_commit;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        RST, MMU_WAIT, TRAP_EN, CHMODE_DO, CSR_WREN;
  logic [31:0] TRAP_PC, TRAP_CODE, TRAP_JMP_TO, CSR_WDATA;
  logic [1:0]  CHMODE_TRANS_TO;
  logic [11:0] CSR_ADDR;
  logic [31:0] CSR_RDATA, NEW_PC, TRAP_VEC_BASE;
  logic        FLUSH, JMP_EN, INT_ALLOW;
  logic [1:0]  MODE, TRAP_VEC_MODE, DBG_STATE;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  trap_commit #(.FLUSH_CYCLES(FC)) dut (
    .CLK(clk), .RST(RST), .MMU_WAIT(MMU_WAIT), .TRAP_EN(TRAP_EN), .TRAP_PC(TRAP_PC),
    .TRAP_CODE(TRAP_CODE), .TRAP_JMP_TO(TRAP_JMP_TO), .CHMODE_DO(CHMODE_DO),
    .CHMODE_TRANS_TO(CHMODE_TRANS_TO), .CSR_WREN(CSR_WREN), .CSR_ADDR(CSR_ADDR),
    .CSR_WDATA(CSR_WDATA), .CSR_RDATA(CSR_RDATA), .FLUSH(FLUSH), .JMP_EN(JMP_EN),
    .NEW_PC(NEW_PC), .MODE(MODE), .INT_ALLOW(INT_ALLOW), .TRAP_VEC_MODE(TRAP_VEC_MODE),
    .TRAP_VEC_BASE(TRAP_VEC_BASE), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    MMU_WAIT = 1'b0; TRAP_EN = 1'b0; CHMODE_DO = 1'b0; CSR_WREN = 1'b0;
    TRAP_PC = '0; TRAP_CODE = '0; TRAP_JMP_TO = '0; CSR_WDATA = '0;
    CHMODE_TRANS_TO = 2'b00; CSR_ADDR = '0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    CSR_WREN = 1'b1; CSR_ADDR = a; CSR_WDATA = d;
    tick();
    CSR_WREN = 1'b0;
  endtask

  task automatic csr_check(input string name, input logic [11:0] a, input logic [31:0] exp);
    CSR_ADDR = a;
    #2;
    check(name, CSR_RDATA, exp);
  endtask

  task automatic trap_req(input logic [31:0] pc, input logic [31:0] code, input logic [31:0] to);
    exp_q.push_back(to);
    TRAP_EN = 1'b1; TRAP_PC = pc; TRAP_CODE = code; TRAP_JMP_TO = to;
    tick();
    TRAP_EN = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((FLUSH || DBG_STATE != 2'd0) && n < 20) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", 32'(n < 20), 32'd1);
  endtask

  // scoreboard monitor: redirect targets and flush run length
  int run = 0;
  always @(negedge clk) begin
    if (JMP_EN) begin
      if (exp_q.size() == 0) begin
        check("unexpected_jmp", NEW_PC, 32'hxxxxxxxx);
      end else begin
        check("new_pc", NEW_PC, exp_q.pop_front());
      end
    end
    if (RST) begin
      run = 0;
    end else if (FLUSH) begin
      run++;
    end else if (run > 0) begin
      check("flush_len", 32'(run), 32'(FC));
      run = 0;
    end
  end

  initial begin
    clear_inputs();
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;

    // reset state
    check("rst_mode", 32'(MODE), 32'h3);
    check("rst_flush", 32'(FLUSH), 32'h0);
    check("rst_jmp", 32'(JMP_EN), 32'h0);
    check("rst_int_allow", 32'(INT_ALLOW), 32'h0);
    check("rst_new_pc", NEW_PC, 32'h0);
    csr_check("rst_mtvec", 12'h305, 32'h0);
    csr_check("rst_mstatus", 12'h300, 32'h0);

    // trap with vectored mtvec and MIE set
    csr_write(12'h305, 32'h8000_0001);
    csr_write(12'h300, 32'h0000_0008);
    csr_check("mtvec_wr", 12'h305, 32'h8000_0001);
    check("int_allow_on", 32'(INT_ALLOW), 32'h1);
    check("vec_mode", 32'(TRAP_VEC_MODE), 32'h1);
    check("vec_base", TRAP_VEC_BASE, 32'h8000_0000);
    trap_req(32'h1006, 32'd8, 32'h8000_0020);
    check("int_allow_redirect", 32'(INT_ALLOW), 32'h0);
    wait_idle();
    csr_check("trap_mepc", 12'h341, 32'h1004);
    csr_check("trap_mcause", 12'h342, 32'd8);
    csr_check("trap_mstatus", 12'h300, 32'h1880);
    check("trap_mode", 32'(MODE), 32'h3);

    // xRET back to U, requested mode disagrees with MPP
    csr_write(12'h300, 32'h0000_0080);
    csr_write(12'h341, 32'h2000);
    exp_q.push_back(32'h2000);
    CHMODE_DO = 1'b1; CHMODE_TRANS_TO = 2'b11;
    tick();
    CHMODE_DO = 1'b0;
    wait_idle();
    check("xret_mode", 32'(MODE), 32'h0);
    csr_check("xret_mstatus", 12'h300, 32'h88);
    check("xret_int_allow", 32'(INT_ALLOW), 32'h1);

    // trap + xRET + mepc write together: trap wins, write lost
    CHMODE_DO = 1'b1; CSR_WREN = 1'b1; CSR_ADDR = 12'h341; CSR_WDATA = 32'h5554;
    trap_req(32'h3000, 32'd3, 32'h8000_0100);
    CHMODE_DO = 1'b0; CSR_WREN = 1'b0;
    wait_idle();
    csr_check("simul_mepc", 12'h341, 32'h3000);
    csr_check("simul_mcause", 12'h342, 32'd3);
    csr_check("simul_mstatus", 12'h300, 32'h80);
    check("simul_mode", 32'(MODE), 32'h3);

    // MMU_WAIT blocks events and CSR writes
    MMU_WAIT = 1'b1; TRAP_EN = 1'b1; TRAP_PC = 32'h9000; TRAP_CODE = 32'd11;
    TRAP_JMP_TO = 32'h8000_0400;
    tick();
    TRAP_EN = 1'b0; CSR_WREN = 1'b1; CSR_ADDR = 12'h342; CSR_WDATA = 32'hFF;
    tick();
    clear_inputs();
    check("wait_flush", 32'(FLUSH), 32'h0);
    csr_check("wait_mepc", 12'h341, 32'h3000);
    csr_check("wait_mcause", 12'h342, 32'd3);

    // events and writes during REDIRECT/DRAIN are ignored
    trap_req(32'h4000, 32'd5, 32'h8000_0200);
    TRAP_EN = 1'b1; TRAP_PC = 32'h5000; TRAP_CODE = 32'd7; TRAP_JMP_TO = 32'h8000_0300;
    CSR_WREN = 1'b1; CSR_ADDR = 12'h342; CSR_WDATA = 32'hDEAD;
    tick(); tick();
    clear_inputs();
    wait_idle();
    csr_check("drain_mepc", 12'h341, 32'h4000);
    csr_check("drain_mcause", 12'h342, 32'd5);
    csr_check("drain_mstatus", 12'h300, 32'h1800);

    // WARL masking and unimplemented address
    csr_write(12'h305, 32'h0000_0003);
    csr_check("warl_mtvec", 12'h305, 32'h0);
    check("warl_vec_mode", 32'(TRAP_VEC_MODE), 32'h0);
    csr_write(12'h300, 32'h0000_1088);
    csr_check("warl_mstatus", 12'h300, 32'h88);
    csr_write(12'h341, 32'h0000_1237);
    csr_check("warl_mepc", 12'h341, 32'h1234);
    csr_check("unimpl_rd", 12'h123, 32'h0);
`ifdef TRAP_COUNTER_EN
    csr_check("trap_cnt", 12'h7C0, 32'd3);
    csr_write(12'h7C0, 32'hFFFF_FFFF);
    csr_check("trap_cnt_wr", 12'h7C0, 32'hFFFF_FFFF);
`else
    csr_write(12'h7C0, 32'h1234_5678);
    csr_check("trap_cnt_absent", 12'h7C0, 32'h0);
`endif

    // reset while in REDIRECT
    trap_req(32'h6000, 32'd2, 32'h8000_0500);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rstmid_flush", 32'(FLUSH), 32'h0);
    check("rstmid_jmp", 32'(JMP_EN), 32'h0);
    check("rstmid_mode", 32'(MODE), 32'h3);
    check("rstmid_new_pc", NEW_PC, 32'h0);
    csr_check("rstmid_mepc", 12'h341, 32'h0);
    tick(); tick();

    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
